// File: rtl/tmng_pkg.sv
// Shared types and constants for the time-multiplexed gate array.
// Holds the gate opcodes, the sweep FSM states and the 7-segment lookup table.
package tmng_pkg;

  typedef enum logic [1:0] {
    OP_NAND = 2'b00,
    OP_NOR  = 2'b01,
    OP_XOR  = 2'b10,
    OP_AND  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  // Segment patterns for hex digits 0..F, bit0 = a .. bit6 = g, active-high.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic apply_op(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmng_seg7_decoder.sv
// Combinational hex-to-7-segment decoder; the output register lives in the caller.
module tmng_seg7_decoder
  import tmng_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = SEG7_LUT[nibble];

endmodule

// File: rtl/tmng_array.sv
// Time-multiplexed array of configurable 2-input gates, evaluated one gate per cycle.
// Optional macro TMNG_SEG7_EN adds a registered 7-segment view of gate_out[3:0].
module tmng_array
  import tmng_pkg::*;
#(
  parameter  int NUM_IN    = 8,
  parameter  int NUM_GATES = 16,
  localparam int SEL_W     = $clog2(NUM_IN + NUM_GATES),
  localparam int AW        = $clog2(NUM_GATES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IN-1:0]    in_vec,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [1:0]           cfg_op,
  input  logic [SEL_W-1:0]     cfg_sel_a,
  input  logic [SEL_W-1:0]     cfg_sel_b,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_GATES-1:0] gate_out,
  output logic [6:0]           seg
);

  localparam int              SIG_N     = NUM_IN + NUM_GATES;
  localparam logic [SEL_W:0]  SIG_LIMIT = (SEL_W + 1)'(SIG_N);
  localparam logic [AW-1:0]   LAST_IDX  = AW'(NUM_GATES - 1);

  state_e               state_reg, state_next;
  logic [AW-1:0]        idx_reg;
  logic [NUM_IN-1:0]    snapshot_reg;
  logic [NUM_GATES-1:0] gate_state_reg, gate_state_next, gate_out_reg;
  op_e                  op_tbl    [NUM_GATES];
  logic [SEL_W-1:0]     sel_a_tbl [NUM_GATES];
  logic [SEL_W-1:0]     sel_b_tbl [NUM_GATES];
  logic [SIG_N-1:0]     sig;
  logic                 opnd_a, opnd_b, gate_result;
  logic                 cfg_ok, last_gate;

  assign cfg_ok    = cfg_we && (state_reg == ST_IDLE);
  assign last_gate = (state_reg == ST_EVAL) && (idx_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_GATES; i++) begin
      if (rst) begin
        op_tbl[i]    <= OP_NAND;
        sel_a_tbl[i] <= '0;
        sel_b_tbl[i] <= '0;
      end else if (cfg_ok && (cfg_addr == AW'(i))) begin
        op_tbl[i]    <= op_e'(cfg_op);
        sel_a_tbl[i] <= cfg_sel_a;
        sel_b_tbl[i] <= cfg_sel_b;
      end
    end
  end

  // Gates below idx already hold this sweep's value, the rest still the previous sweep's.
  assign sig = {gate_state_reg, snapshot_reg};

  always_comb begin
    opnd_a = 1'b0;
    opnd_b = 1'b0;
    if ({1'b0, sel_a_tbl[idx_reg]} < SIG_LIMIT) opnd_a = sig[sel_a_tbl[idx_reg]];
    if ({1'b0, sel_b_tbl[idx_reg]} < SIG_LIMIT) opnd_b = sig[sel_b_tbl[idx_reg]];
    gate_result     = apply_op(op_tbl[idx_reg], opnd_a, opnd_b);
    gate_state_next = gate_state_reg;
    if (state_reg == ST_EVAL) gate_state_next[idx_reg] = gate_result;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_EVAL;
      ST_EVAL: if (idx_reg == LAST_IDX) state_next = ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != ST_IDLE);
    done = (state_reg == ST_FIN);
  end

  // gate_out is published on the edge into FIN so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg        <= '0;
      snapshot_reg   <= '0;
      gate_state_reg <= '0;
      gate_out_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            snapshot_reg <= in_vec;
            idx_reg      <= '0;
          end
        end
        ST_EVAL: begin
          gate_state_reg <= gate_state_next;
          if (last_gate) begin
            idx_reg      <= '0;
            gate_out_reg <= gate_state_next;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gate_out = gate_out_reg;

`ifdef TMNG_SEG7_EN
  logic [6:0] seg_pattern, seg_reg;

  tmng_seg7_decoder u_seg7 (
    .nibble (gate_state_next[3:0]),
    .pattern(seg_pattern)
  );

  always_ff @(posedge clk) begin
    if (rst)            seg_reg <= '0;
    else if (last_gate) seg_reg <= seg_pattern;
  end

  assign seg = seg_reg;
`else
  assign seg = '0;
`endif

endmodule

// File: tb/tb_tmng_array.sv
// Self-checking bench for tmng_array: randomized sweeps compared against a behavioural model.
module tb_tmng_array;
  localparam int NI = 8;
  localparam int NG = 16;

  logic        clk = 1'b0;
  logic        rst, cfg_we, start, busy, done;
  logic [7:0]  in_vec;
  logic [3:0]  cfg_addr;
  logic [1:0]  cfg_op;
  logic [4:0]  cfg_sel_a, cfg_sel_b;
  logic [15:0] gate_out;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  int          m_op [NG];
  int          m_a  [NG];
  int          m_b  [NG];
  logic [15:0] m_state;
  logic [15:0] m_out;

  tmng_array #(.NUM_IN(NI), .NUM_GATES(NG)) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_op(cfg_op), .cfg_sel_a(cfg_sel_a), .cfg_sel_b(cfg_sel_b), .start(start),
    .busy(busy), .done(done), .gate_out(gate_out), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int g = 0; g < NG; g++) begin
      m_op[g] = 0; m_a[g] = 0; m_b[g] = 0;
    end
    m_state = '0;
    m_out   = '0;
  endfunction

  function automatic logic m_sig(input logic [7:0] v, input int s);
    if (s < NI) return v[s];
    if (s < NI + NG) return m_state[s - NI];
    return 1'b0;
  endfunction

  function automatic logic m_gate(input int op, input logic a, input logic b);
    case (op)
      0: return !(a && b);
      1: return !(a || b);
      2: return a != b;
      default: return a && b;
    endcase
  endfunction

  function automatic void model_sweep(input logic [7:0] v);
    for (int g = 0; g < NG; g++)
      m_state[g] = m_gate(m_op[g], m_sig(v, m_a[g]), m_sig(v, m_b[g]));
    m_out = m_state;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int addr, input int op, input int a, input int b);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_op = 2'(op); cfg_sel_a = 5'(a); cfg_sel_b = 5'(b);
    @(negedge clk);
    cfg_we = 1'b0;
    m_op[addr] = op; m_a[addr] = a; m_b[addr] = b;
  endtask

  // One sweep; optional mid-sweep poke, start during FIN, and a config write in the start cycle.
  task automatic sweep(input logic [7:0] vec, input bit poke, input bit fin_start,
                       input bit cfg_too, input int ca, input int cop, input int csa, input int csb);
    logic [15:0] prev_out;
    int lat, busy_cnt, done_cnt;
    bit unstable;
    prev_out = m_out;
    if (cfg_too) begin
      m_op[ca] = cop; m_a[ca] = csa; m_b[ca] = csb;
    end
    model_sweep(vec);
    @(negedge clk);
    in_vec = vec; start = 1'b1;
    if (cfg_too) begin
      cfg_we = 1'b1; cfg_addr = 4'(ca); cfg_op = 2'(cop); cfg_sel_a = 5'(csa); cfg_sel_b = 5'(csb);
    end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0; in_vec = 8'($urandom);
    lat = -1; busy_cnt = 0; done_cnt = 0; unstable = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (lat < 0) lat = k;
        if (fin_start) start = 1'b1;
      end
      if (k < 16 && gate_out !== prev_out) unstable = 1'b1;
      if (poke && k == 5) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_op = 2'd3;
        cfg_sel_a = 5'd31; cfg_sel_b = 5'd31;
      end
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0; in_vec = 8'($urandom);
    end
    $display("sweep vec=%h gate_out=%h expect=%h latency=%0d busy_cycles=%0d dones=%0d",
             vec, gate_out, m_out, lat, busy_cnt, done_cnt);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL latency: got %0d want 16", lat); end
    checks++;
    if (busy_cnt !== 17) begin errors++; $display("FAIL busy_cycles: got %0d want 17", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL done_count: got %0d want 1", done_cnt); end
    checks++;
    if (gate_out !== m_out) begin errors++; $display("FAIL gate_out: got %h want %h", gate_out, m_out); end
    checks++;
    if (unstable) begin errors++; $display("FAIL gate_out_stable: changed before done, want %h", prev_out); end
    checks++;
`ifdef TMNG_SEG7_EN
    if (seg !== exp_seg(m_out[3:0])) begin
      errors++; $display("FAIL seg: got %h want %h", seg, exp_seg(m_out[3:0]));
    end
`else
    if (seg !== 7'h00) begin errors++; $display("FAIL seg: got %h want 00", seg); end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (gate_out !== 16'h0000) begin errors++; $display("FAIL reset_gate_out: got %h want 0000", gate_out); end
    checks++;
    if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h want 00", seg); end
  endtask

  task automatic test_default_sweep();
    do_reset();
    sweep(8'h00, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (gate_out !== 16'hFFFF) begin errors++; $display("FAIL default_all_nand: got %h want ffff", gate_out); end
  endtask

  task automatic test_xor_and();
    do_reset();
    cfg_write(0, 2, 0, 1);
    cfg_write(1, 3, 0, 1);
    sweep(8'h03, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (gate_out[1:0] !== 2'b10) begin errors++; $display("FAIL xor_and: got %b want 10", gate_out[1:0]); end
`ifdef TMNG_SEG7_EN
    checks++;
    if (seg !== 7'h5B) begin errors++; $display("FAIL xor_and_seg: got %h want 5b", seg); end
`endif
  endtask

  task automatic test_feedback();
    logic exp_bits [3];
    exp_bits = '{1'b1, 1'b0, 1'b1};
    do_reset();
    cfg_write(0, 1, 8, 8);
    for (int i = 0; i < 3; i++) begin
      sweep(8'($urandom), 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (gate_out[0] !== exp_bits[i]) begin
        errors++; $display("FAIL feedback_%0d: got %b want %b", i, gate_out[0], exp_bits[i]);
      end
    end
  endtask

  task automatic test_mid_sweep_poke();
    cfg_write(0, 0, 31, 31);
    sweep(8'($urandom), 1, 0, 0, 0, 0, 0, 0);
    sweep(8'($urandom), 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (gate_out[0] !== 1'b1) begin errors++; $display("FAIL poke_dropped: got %b want 1", gate_out[0]); end
  endtask

  task automatic test_fin_start();
    sweep(8'($urandom), 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_sweep();
    int dones;
    cfg_write(3, 2, 1, 9);
    sweep(8'hA5, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    in_vec = 8'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++;
    if (gate_out !== 16'h0000) begin errors++; $display("FAIL abort_gate_out: got %h want 0000", gate_out); end
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    sweep(8'($urandom), 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_out_of_range();
    int g;
    for (int i = 0; i < 3; i++) begin
      g = $urandom_range(0, NG - 1);
      cfg_write(g, 0, 31, $urandom_range(0, 31));
      sweep(8'($urandom), 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (gate_out[g] !== 1'b1) begin errors++; $display("FAIL out_of_range_g%0d: got %b want 1", g, gate_out[g]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3))
        cfg_write($urandom_range(0, NG - 1), $urandom_range(0, 3),
                  $urandom_range(0, 31), $urandom_range(0, 31));
      sweep(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), $urandom_range(0, NG - 1), $urandom_range(0, 3),
            $urandom_range(0, 31), $urandom_range(0, 31));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; in_vec = '0;
    cfg_addr = '0; cfg_op = '0; cfg_sel_a = '0; cfg_sel_b = '0;
    model_reset();
    test_reset();
    test_default_sweep();
    test_xor_and();
    test_feedback();
    test_mid_sweep_poke();
    test_fin_start();
    test_reset_mid_sweep();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
